// File: rtl/regfile_operand_fetch_pkg.sv
// Shared widths and types for the operand-fetch stage of the 16x16 register file.
package regfile_operand_fetch_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREG   = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  // Operand bundle handed to execute
  typedef struct packed {
    data_t    a;
    data_t    b;
    reg_idx_t dst;
    logic     wr_en;
  } op_bundle_t;

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Issue, writeback, register-file and execute-side signals of the operand-fetch stage.
// slave is the fetch block's view; master is everything around it.
interface regfile_operand_fetch_if;
  import regfile_operand_fetch_pkg::*;

  logic     issue_valid;
  logic     issue_ready;
  reg_idx_t issue_src1;
  reg_idx_t issue_src2;
  reg_idx_t issue_dst;
  logic     issue_wr_en;

  logic     wb_valid;
  reg_idx_t wb_reg;
  data_t    wb_data;

  reg_idx_t srcReg_1;
  reg_idx_t srcReg_2;
  data_t    srcData_1;
  data_t    srcData_2;
  reg_idx_t dstReg;
  logic     writeReg;
  data_t    dstData;

  logic     op_valid;
  logic     op_ready;
  data_t    op_a;
  data_t    op_b;
  reg_idx_t op_dst;
  logic     op_wr_en;

  modport slave (
    input  issue_valid, issue_src1, issue_src2, issue_dst, issue_wr_en,
    output issue_ready,
    input  wb_valid, wb_reg, wb_data,
    output srcReg_1, srcReg_2, dstReg, writeReg, dstData,
    input  srcData_1, srcData_2,
    output op_valid, op_a, op_b, op_dst, op_wr_en,
    input  op_ready
  );

  modport master (
    output issue_valid, issue_src1, issue_src2, issue_dst, issue_wr_en,
    input  issue_ready,
    output wb_valid, wb_reg, wb_data,
    input  srcReg_1, srcReg_2, dstReg, writeReg, dstData,
    output srcData_1, srcData_2,
    input  op_valid, op_a, op_b, op_dst, op_wr_en,
    output op_ready
  );

endinterface

// File: rtl/regfile_operand_fetch_reg_scoreboard.sv
// Pending-write scoreboard: one flag per register, set by issue, cleared by writeback.
// A set and clear of the same register in one cycle leaves it pending, since the
// newly issued writer has not completed yet.
module reg_scoreboard
  import regfile_operand_fetch_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_set_en,
  input  reg_idx_t i_set_idx,
  input  logic     i_clr_en,
  input  reg_idx_t i_clr_idx,
  input  reg_idx_t i_src1,
  input  reg_idx_t i_src2,
  input  reg_idx_t i_dst,
  output logic     o_pend_src1,
  output logic     o_pend_src2,
  output logic     o_pend_dst
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  // One-hot decode of the set and clear requests
  for (genvar g = 0; g < NREG; g++) begin : g_dec
    assign w_set[g] = i_set_en && (i_set_idx == reg_idx_t'(g));
    assign w_clr[g] = i_clr_en && (i_clr_idx == reg_idx_t'(g));
  end

  // Clear first, then set, so a same-cycle set dominates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pending <= '0;
    else      r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign o_pend_src1 = r_pending[i_src1];
  assign o_pend_src2 = r_pending[i_src2];
  assign o_pend_dst  = r_pending[i_dst];

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch: drives the register-file ports, stalls on RAW/WAW against pending
// writes, forwards same-cycle writeback data and registers one operand bundle for execute.
module regfile_operand_fetch
  import regfile_operand_fetch_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  regfile_operand_fetch_if.slave bus
);

  logic       w_fwd1, w_fwd2, w_wb_dst;
  logic       w_pend1, w_pend2, w_pend_dst;
  logic       w_haz1, w_haz2, w_waw;
  logic       w_ready, w_accept;
  op_bundle_t r_op;
  logic       r_op_valid;

  // Register-file ports are straight pass-throughs
  assign bus.srcReg_1 = bus.issue_src1;
  assign bus.srcReg_2 = bus.issue_src2;
  assign bus.dstReg   = bus.wb_reg;
  assign bus.writeReg = bus.wb_valid;
  assign bus.dstData  = bus.wb_data;

  // The file commits writes only at the edge, so a same-cycle writeback must be forwarded
  assign w_fwd1   = bus.wb_valid && (bus.wb_reg == bus.issue_src1);
  assign w_fwd2   = bus.wb_valid && (bus.wb_reg == bus.issue_src2);
  assign w_wb_dst = bus.wb_valid && (bus.wb_reg == bus.issue_dst);

  reg_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_set_en    (w_accept && bus.issue_wr_en),
    .i_set_idx   (bus.issue_dst),
    .i_clr_en    (bus.wb_valid),
    .i_clr_idx   (bus.wb_reg),
    .i_src1      (bus.issue_src1),
    .i_src2      (bus.issue_src2),
    .i_dst       (bus.issue_dst),
    .o_pend_src1 (w_pend1),
    .o_pend_src2 (w_pend2),
    .o_pend_dst  (w_pend_dst)
  );

  // A writeback landing this cycle resolves the hazard on its register
  assign w_haz1   = w_pend1 && !w_fwd1;
  assign w_haz2   = w_pend2 && !w_fwd2;
  assign w_waw    = bus.issue_wr_en && w_pend_dst && !w_wb_dst;
  assign w_ready  = (!r_op_valid || bus.op_ready) && !w_haz1 && !w_haz2 && !w_waw;
  assign w_accept = bus.issue_valid && w_ready;

  assign bus.issue_ready = w_ready;

  // Operand register: load on accept, drop when consumed, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_valid <= 1'b0;
      r_op       <= '0;
    end else if (w_accept) begin
      r_op_valid <= 1'b1;
      r_op.a     <= w_fwd1 ? bus.wb_data : bus.srcData_1;
      r_op.b     <= w_fwd2 ? bus.wb_data : bus.srcData_2;
      r_op.dst   <= bus.issue_dst;
      r_op.wr_en <= bus.issue_wr_en;
    end else if (bus.op_ready) begin
      r_op_valid <= 1'b0;
    end
  end

  assign bus.op_valid = r_op_valid;
  assign bus.op_a     = r_op.a;
  assign bus.op_b     = r_op.b;
  assign bus.op_dst   = r_op.dst;
  assign bus.op_wr_en = r_op.wr_en;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: a modelled register file behind the read/write ports,
// a directed vector table, an async-reset sequence and a randomized phase checked
// against a "latest value / outstanding writes" reference model.
module tb_regfile_operand_fetch;
  import regfile_operand_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_operand_fetch_if bus();

  regfile_operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Register file attached to the DUT's ports
  logic [15:0] rf [16];
  assign bus.srcData_1 = rf[bus.srcReg_1];
  assign bus.srcData_2 = rf[bus.srcReg_2];

  // Reference model: set of registers with an outstanding writer, plus the held bundle
  bit [15:0]   m_pend;
  bit          m_valid;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_dst;
  logic        m_wr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv;
    logic [3:0]  s1, s2, dst;
    logic        wr;
    logic        wbv;
    logic [3:0]  wbr;
    logic [15:0] wbd;
    logic        opr;
    logic        e_rdy;
    logic        e_ov;
    logic [15:0] e_a, e_b;
    logic [3:0]  e_dst;
    logic        e_wr;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.issue_valid = v.iv;
    bus.issue_src1  = v.s1;
    bus.issue_src2  = v.s2;
    bus.issue_dst   = v.dst;
    bus.issue_wr_en = v.wr;
    bus.wb_valid    = v.wbv;
    bus.wb_reg      = v.wbr;
    bus.wb_data     = v.wbd;
    bus.op_ready    = v.opr;
  endtask

  // One clock: entered and left 1 time unit after a rising edge
  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    bit [15:0]   eff;
    bit          rdy, acc;
    logic [15:0] na, nb;
    drive(v);
    #1;
    // Registers still effectively outstanding once this cycle's writeback lands
    eff = m_pend;
    if (v.wbv) eff[v.wbr] = 1'b0;
    rdy = (!m_valid || v.opr) && !eff[v.s1] && !eff[v.s2] && !(v.wr && eff[v.dst]);
    chk({tag, ".ready"}, 32'(bus.issue_ready), 32'(rdy));
    if (use_tbl) chk({tag, ".ready_tbl"}, 32'(bus.issue_ready), 32'(v.e_rdy));
    chk({tag, ".srcReg_1"}, 32'(bus.srcReg_1), 32'(v.s1));
    chk({tag, ".srcReg_2"}, 32'(bus.srcReg_2), 32'(v.s2));
    chk({tag, ".writeReg"}, 32'(bus.writeReg), 32'(v.wbv));
    chk({tag, ".dstReg"},   32'(bus.dstReg),   32'(v.wbr));
    chk({tag, ".dstData"},  32'(bus.dstData),  32'(v.wbd));
    acc = v.iv && rdy;
    // Operands are the newest value of each register, including this cycle's write
    na = (v.wbv && v.wbr == v.s1) ? v.wbd : rf[v.s1];
    nb = (v.wbv && v.wbr == v.s2) ? v.wbd : rf[v.s2];
    @(posedge clk);
    #1;
    if (v.wbv) begin
      rf[v.wbr]     = v.wbd;
      m_pend[v.wbr] = 1'b0;
    end
    if (acc) begin
      if (v.wr) m_pend[v.dst] = 1'b1;
      m_valid = 1'b1;
      m_a = na; m_b = nb; m_dst = v.dst; m_wr = v.wr;
    end else if (v.opr) begin
      m_valid = 1'b0;
    end
    chk({tag, ".op_valid"}, 32'(bus.op_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".op_a"},     32'(bus.op_a),     32'(m_a));
      chk({tag, ".op_b"},     32'(bus.op_b),     32'(m_b));
      chk({tag, ".op_dst"},   32'(bus.op_dst),   32'(m_dst));
      chk({tag, ".op_wr_en"}, 32'(bus.op_wr_en), 32'(m_wr));
    end
    if (use_tbl) begin
      chk({tag, ".op_valid_tbl"}, 32'(bus.op_valid), 32'(v.e_ov));
      if (v.e_ov) begin
        chk({tag, ".op_a_tbl"},     32'(bus.op_a),     32'(v.e_a));
        chk({tag, ".op_b_tbl"},     32'(bus.op_b),     32'(v.e_b));
        chk({tag, ".op_dst_tbl"},   32'(bus.op_dst),   32'(v.e_dst));
        chk({tag, ".op_wr_en_tbl"}, 32'(bus.op_wr_en), 32'(v.e_wr));
      end
    end
  endtask

  vec_t vr;

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'hA000 + 16'(i);
    rf[2] = 16'h1111;
    rf[3] = 16'h2222;
    m_pend = '0; m_valid = 1'b0; m_a = '0; m_b = '0; m_dst = '0; m_wr = 1'b0;

    // iv s1 s2 dst wr | wbv wbr wbd | opr || rdy ov a b dst wr
    tbl[0]  = '{1,2,3,4,1, 0,0,16'h0,   1, 1,1,16'h1111,16'h2222,4,1}; // basic fetch
    tbl[1]  = '{1,4,0,5,0, 0,0,16'h0,   1, 0,0,16'h0,16'h0,0,0};       // RAW stall
    tbl[2]  = '{1,4,0,5,0, 0,0,16'h0,   1, 0,0,16'h0,16'h0,0,0};
    tbl[3]  = '{1,4,0,5,0, 0,0,16'h0,   1, 0,0,16'h0,16'h0,0,0};
    tbl[4]  = '{1,4,0,5,0, 1,4,16'hBEEF,1, 1,1,16'hBEEF,16'hA000,5,0}; // forwarded
    tbl[5]  = '{1,0,1,7,1, 0,0,16'h0,   1, 1,1,16'hA000,16'hA001,7,1};
    tbl[6]  = '{1,0,0,7,1, 1,7,16'h7777,1, 1,1,16'hA000,16'hA000,7,1}; // WAW resolved, set wins
    tbl[7]  = '{1,1,1,7,1, 0,0,16'h0,   1, 0,0,16'h0,16'h0,0,0};       // WAW stall
    tbl[8]  = '{0,1,1,7,1, 1,7,16'h7070,1, 1,0,16'h0,16'h0,0,0};
    tbl[9]  = '{0,1,1,7,1, 1,9,16'h9999,1, 1,0,16'h0,16'h0,0,0};       // wb to non-pending
    tbl[10] = '{1,9,7,0,0, 0,0,16'h0,   1, 1,1,16'h9999,16'h7070,0,0};
    tbl[11] = '{1,3,3,3,1, 1,3,16'h3333,1, 1,1,16'h3333,16'h3333,3,1}; // src1==src2 forwarded
    tbl[12] = '{1,3,3,1,0, 0,0,16'h0,   1, 0,0,16'h0,16'h0,0,0};
    tbl[13] = '{0,3,3,1,0, 1,3,16'h3030,1, 1,0,16'h0,16'h0,0,0};
    tbl[14] = '{1,2,3,8,0, 0,0,16'h0,   1, 1,1,16'h1111,16'h3030,8,0}; // backpressure start
    for (int i = 15; i < 20; i++)
      tbl[i] = '{1,5,6,9,0, 0,0,16'h0, 0, 0,1,16'h1111,16'h3030,8,0};  // held 5 cycles
    tbl[20] = '{1,5,6,9,0, 0,0,16'h0,   1, 1,1,16'hA005,16'hA006,9,0}; // back-to-back
    tbl[21] = '{0,0,0,0,0, 0,0,16'h0,   1, 1,0,16'h0,16'h0,0,0};
    tbl[22] = '{1,0,0,4,1, 0,0,16'h0,   1, 1,1,16'hA000,16'hA000,4,1};
    tbl[23] = '{1,1,1,7,1, 0,0,16'h0,   1, 1,1,16'hA001,16'hA001,7,1}; // pending = 0x0090
    tbl[24] = '{1,4,7,7,1, 0,0,16'h0,   1, 1,1,16'hBEEF,16'h7070,7,1}; // first issue after reset

    drive(tbl[21]);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.op_valid", 32'(bus.op_valid), 32'd0);
    chk("reset.op_a",     32'(bus.op_a),     32'd0);
    chk("reset.op_b",     32'(bus.op_b),     32'd0);
    chk("reset.op_dst",   32'(bus.op_dst),   32'd0);
    chk("reset.op_wr_en", 32'(bus.op_wr_en), 32'd0);
    chk("reset.ready",    32'(bus.issue_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Asynchronous reset between edges with a held bundle and r4/r7 pending
    #2;
    rst = 1'b0;
    drive('{1,4,7,7,1, 0,0,16'h0, 0, 0,0,16'h0,16'h0,0,0});
    #1;
    chk("async.op_valid", 32'(bus.op_valid), 32'd0);
    chk("async.op_a",     32'(bus.op_a),     32'd0);
    chk("async.op_b",     32'(bus.op_b),     32'd0);
    chk("async.op_dst",   32'(bus.op_dst),   32'd0);
    chk("async.op_wr_en", 32'(bus.op_wr_en), 32'd0);
    chk("async.ready",    32'(bus.issue_ready), 32'd1);
    m_pend = '0;
    m_valid = 1'b0;
    bus.issue_valid = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(tbl[24], 1'b1, "vec24");

    // Randomized traffic on a narrow register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      vr = '{default: '0};
      vr.iv  = ($urandom_range(0, 9) < 8);
      vr.s1  = 4'($urandom_range(0, 7));
      vr.s2  = 4'($urandom_range(0, 7));
      vr.dst = 4'($urandom_range(0, 7));
      vr.wr  = ($urandom_range(0, 3) != 0);
      vr.wbv = ($urandom_range(0, 9) < 4);
      vr.wbr = 4'($urandom_range(0, 7));
      vr.wbd = 16'($urandom);
      vr.opr = ($urandom_range(0, 3) != 0);
      step(vr, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
